// File: rtl/vctr_frame_parser.sv
// vctr_frame_parser: decodes 3-byte command frames (header, channel, data)
// from the UART receive stage and writes the data byte into one of the
// vector registers. Frames are aborted on framing error, bad channel or
// inter-byte timeout; aborts are reported by a pulse and a saturating count.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for the header byte, counter held at 0
// S_CHAN | header seen, waiting for the channel index
// S_DATA | channel latched, waiting for the data byte
module vctr_frame_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         NUM_CH         = 3,
  parameter int         TIMEOUT_CYCLES = 60000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_ferr,
  output logic [7:0] vctr0,
  output logic [7:0] vctr1,
  output logic [7:0] vctr2,
  output logic       upd,
  output logic [1:0] upd_ch,
  output logic       frm_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int             CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     NUM_CH_B = 8'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_DATA} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] to_cnt, to_cnt_nx;
  logic [1:0]    ch, ch_nx;
  logic          abort;
  logic          wr_en;

  logic [7:0]    vctr0_nx, vctr1_nx, vctr2_nx;
  logic          upd_nx;
  logic [1:0]    upd_ch_nx;
  logic          frm_err_nx;
  logic [7:0]    err_cnt_nx;
  logic          busy_nx;

  // State, timeout counter, channel latch and all registered outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      to_cnt  <= '0;
      ch      <= 2'd0;
      vctr0   <= 8'h00;
      vctr1   <= 8'h00;
      vctr2   <= 8'h00;
      upd     <= 1'b0;
      upd_ch  <= 2'd0;
      frm_err <= 1'b0;
      err_cnt <= 8'h00;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      to_cnt  <= to_cnt_nx;
      ch      <= ch_nx;
      vctr0   <= vctr0_nx;
      vctr1   <= vctr1_nx;
      vctr2   <= vctr2_nx;
      upd     <= upd_nx;
      upd_ch  <= upd_ch_nx;
      frm_err <= frm_err_nx;
      err_cnt <= err_cnt_nx;
      busy    <= busy_nx;
    end
  end

  // Next-state decode; event priority is framing error, then byte, then timeout.
  always_comb begin
    state_nx  = state;
    to_cnt_nx = to_cnt;
    ch_nx     = ch;
    abort     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        to_cnt_nx = '0;
        // A byte flagged with a framing error is corrupt, so it cannot start a frame.
        if (rx_valid && !rx_ferr && (rx_byte == HEADER)) begin
          state_nx = S_CHAN;
        end
      end
      S_CHAN: begin
        if (rx_ferr) begin
          abort = 1'b1;
        end else if (rx_valid) begin
          if (rx_byte < NUM_CH_B) begin
            state_nx  = S_DATA;
            ch_nx     = rx_byte[1:0];
            to_cnt_nx = '0;
          end else begin
            abort = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          abort = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          abort = 1'b1;
        end else if (rx_valid) begin
          wr_en     = 1'b1;
          state_nx  = S_IDLE;
          to_cnt_nx = '0;
        end else if (to_cnt == TO_LAST) begin
          abort = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + CW'(1);
        end
      end
      default: begin
        state_nx  = S_IDLE;
        to_cnt_nx = '0;
      end
    endcase
    if (abort) begin
      state_nx  = S_IDLE;
      to_cnt_nx = '0;
    end
  end

  // Next values of the registered outputs, derived from the decoded events.
  always_comb begin
    vctr0_nx   = vctr0;
    vctr1_nx   = vctr1;
    vctr2_nx   = vctr2;
    upd_ch_nx  = upd_ch;
    err_cnt_nx = err_cnt;
    upd_nx     = wr_en;
    frm_err_nx = abort;
    busy_nx    = (state_nx != S_IDLE);
    if (wr_en) begin
      upd_ch_nx = ch;
      case (ch)
        2'd0:    vctr0_nx = rx_byte;
        2'd1:    vctr1_nx = rx_byte;
        2'd2:    vctr2_nx = rx_byte;
        default: ;
      endcase
    end
    if (abort && (err_cnt != 8'hFF)) begin
      err_cnt_nx = err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vctr_frame_parser.sv
// Bench for vctr_frame_parser: reset checks, a table of frames with
// hand-written expectations, timeout corner cases, a randomized run against
// a frame-level reference model, error-count saturation and async reset.
module tb_vctr_frame_parser;

  localparam int         TO  = 64;
  localparam int         NCH = 3;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clock;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic [7:0] vctr0, vctr1, vctr2;
  logic       upd;
  logic [1:0] upd_ch;
  logic       frm_err;
  logic [7:0] err_cnt;
  logic       busy;

  vctr_frame_parser #(
    .HEADER(HDR),
    .NUM_CH(NCH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_ferr(rx_ferr),
    .vctr0(vctr0),
    .vctr1(vctr1),
    .vctr2(vctr2),
    .upd(upd),
    .upd_ch(upd_ch),
    .frm_err(frm_err),
    .err_cnt(err_cnt),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int upd_seen = 0;
  int ferr_seen = 0;

  // Reference model: frame position, cycles since the last accepted byte.
  int         m_phase;
  int         m_gap;
  int         m_ch;
  logic [7:0] m_v [4];
  logic [7:0] m_err;
  logic       m_upd;
  logic [1:0] m_uch;
  logic       m_frm;

  typedef struct {
    logic [7:0] b;
    logic       e_upd;
    logic [1:0] e_ch;
    logic       e_ferr;
  } vec_t;

  vec_t tbl [$];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_gap   = 0;
    m_ch    = 0;
    for (int i = 0; i < 4; i++) m_v[i] = 8'h00;
    m_err = 8'h00;
    m_upd = 1'b0;
    m_uch = 2'd0;
    m_frm = 1'b0;
  endfunction

  function automatic void model_abort();
    m_phase = 0;
    m_gap   = 0;
    m_frm   = 1'b1;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic void model_edge(logic v, logic [7:0] b, logic f);
    m_upd = 1'b0;
    m_frm = 1'b0;
    if (m_phase == 0) begin
      if (v && !f && b == HDR) begin
        m_phase = 1;
        m_gap   = 0;
      end
    end else if (f) begin
      model_abort();
    end else if (v) begin
      if (m_phase == 1) begin
        if (int'(b) < NCH) begin
          m_ch    = int'(b);
          m_phase = 2;
          m_gap   = 0;
        end else begin
          model_abort();
        end
      end else begin
        m_v[m_ch] = b;
        m_upd     = 1'b1;
        m_uch     = 2'(m_ch);
        m_phase   = 0;
        m_gap     = 0;
      end
    end else if (m_gap == TO - 1) begin
      model_abort();
    end else begin
      m_gap++;
    end
  endfunction

  function automatic logic [63:0] dut_bundle();
    return 64'({vctr0, vctr1, vctr2, upd, upd_ch, frm_err, err_cnt, busy});
  endfunction

  function automatic logic [63:0] model_bundle();
    logic b;
    b = (m_phase != 0);
    return 64'({m_v[0], m_v[1], m_v[2], m_upd, m_uch, m_frm, m_err, b});
  endfunction

  task automatic step(input logic v, input logic [7:0] b, input logic f);
    rx_valid = v;
    rx_byte  = b;
    rx_ferr  = f;
    @(posedge clock);
    model_edge(v, b, f);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rx_ferr  = 1'b0;
    if (upd) upd_seen++;
    if (frm_err) ferr_seen++;
    chk("model", dut_bundle(), model_bundle());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int r;
    int pick;
    logic [7:0] b;
    logic f;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rx_ferr  = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", dut_bundle(), 64'd0);
    rst = 1'b0;

    // Single frame with spaced bytes.
    upd_seen = 0;
    step(1'b1, 8'hA5, 1'b0); idle(20);
    step(1'b1, 8'h01, 1'b0); idle(20);
    step(1'b1, 8'hAA, 1'b0);
    chk("t1_upd_ch", 64'({upd, upd_ch}), 64'({1'b1, 2'd1}));
    idle(3);
    chk("t1_regs", 64'({vctr0, vctr1, vctr2, err_cnt}), 64'({8'h00, 8'hAA, 8'h00, 8'h00}));
    chk("t1_upd_count", 64'(upd_seen), 64'd1);

    // Table of frames: writes, dropped bytes, bad channel.
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h00, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h01, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h02, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'hCC, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h01, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'hDD, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h00, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'hEE, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h02, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{8'h33, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'hA5, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{8'h03, 1'b0, 2'd0, 1'b1});
    tbl.push_back('{8'h44, 1'b0, 2'd0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].b, 1'b0);
      chk("tbl_pulse", 64'({upd, upd ? upd_ch : 2'd0, frm_err}),
          64'({tbl[i].e_upd, tbl[i].e_ch, tbl[i].e_ferr}));
    end
    idle(2);
    chk("tbl_final", 64'({vctr0, vctr1, vctr2, err_cnt}), 64'({8'hEE, 8'hDD, 8'hFF, 8'h01}));

    // Timeout with no further byte.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle(TO - 1);
    chk("to_not_yet", 64'({frm_err, busy}), 64'({1'b0, 1'b1}));
    idle(1);
    chk("to_fire", 64'({frm_err, busy, err_cnt}), 64'({1'b1, 1'b0, 8'h02}));
    idle(5);
    step(1'b1, 8'hAA, 1'b0);
    chk("to_late_byte", 64'({upd, frm_err, vctr1}), 64'({1'b0, 1'b0, 8'hDD}));

    // Byte on the expiry cycle is accepted.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'hAA, 1'b0);
    chk("to_edge_accept", 64'({upd, upd_ch, frm_err, vctr1, err_cnt}),
        64'({1'b1, 2'd1, 1'b0, 8'hAA, 8'h02}));

    // Same, but with a framing error on that byte.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'hBB, 1'b1);
    chk("to_edge_ferr", 64'({upd, frm_err, vctr1, err_cnt}), 64'({1'b0, 1'b1, 8'hAA, 8'h03}));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        step(1'b0, 8'h00, ($urandom_range(0, 29) == 0));
      end else if (r == 99) begin
        idle(TO - 3 + int'($urandom_range(0, 4)));
      end else begin
        pick = int'($urandom_range(0, 5));
        if (pick < 2) b = HDR;
        else if (pick < 4) b = 8'($urandom_range(0, 3));
        else b = 8'($urandom());
        f = ($urandom_range(0, 19) == 0);
        step(1'b1, b, f);
      end
    end

    // Error count saturation.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h07, 1'b0);
    end
    chk("sat_ff", 64'(err_cnt), 64'hFF);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    chk("sat_hold", 64'({frm_err, err_cnt}), 64'({1'b1, 8'hFF}));

    // Asynchronous reset in mid-frame.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", dut_bundle(), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk("post_reset_frame", 64'({vctr0, vctr1, vctr2, upd, upd_ch}),
        64'({8'h00, 8'h00, 8'h11, 1'b1, 2'd2}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
